// File: rtl/mc_seq.sv
// mc_seq -- machine-cycle sequencer for an 8051-style core.
//
// Every machine cycle is six non-stalled clocks (phases S1..S6). An
// instruction starts with a FETCH cycle. The opcode is decoded once at
// FETCH S2 into the number of remaining machine cycles, and EXEC cycles
// follow until that count runs out. When MC_SEQ_INT_EN is defined, a
// pending interrupt can be taken at the end of an instruction. It then
// inserts a two-cycle ISLOT (vector-call slot) before the next fetch.
//
// Configuration macro: MC_SEQ_INT_EN
//   defined   -> interrupt slot implemented (int_req sampled, int_ack driven)
//   undefined -> int_req ignored, int_ack tied low, ISLOT never entered
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   synchronous active-high reset (has priority over stall)
//   stall    in   freeze every register; strobes are held low while set
//   IR[7:0]  in   instruction register contents, valid from S2 of FETCH
//   int_req  in   prioritised interrupt request level
//   state    out  current phase, S1..S6 encoded 3'd1..3'd6
//   cycles   out  machine cycles remaining after the current one
//   IR_en    out  instruction-register load strobe (FETCH S1)
//   PC_inc   out  program-counter increment strobe (FETCH S1)
//   int_ack  out  interrupt vector-call strobe (first ISLOT S1)
//   first    out  high for the whole first cycle of an instruction or slot
module mc_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic [7:0] IR,
  input  logic       int_req,
  output logic [2:0] state,
  output logic [1:0] cycles,
  output logic       IR_en,
  output logic       PC_inc,
  output logic       int_ack,
  output logic       first
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    ISLOT = 2'd2
  } fsm_t;

  // Instruction length minus one, in machine cycles.
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len_m1;
    len_m1 = 2'd0;
    if ((op == 8'h84) || (op == 8'hA4)) begin
      len_m1 = 2'd3;
    end else if ((op[4:0] == 5'b00001) || (op[4:0] == 5'b10001)) begin
      len_m1 = 2'd1;
    end else if (((op >= 8'hB4) && (op <= 8'hBF)) ||
                 ((op >= 8'hD8) && (op <= 8'hDF))) begin
      len_m1 = 2'd1;
    end else begin
      case (op)
        8'h02, 8'h12, 8'h22, 8'h32,
        8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
        8'h73, 8'h83, 8'h93, 8'h90, 8'hA3, 8'hC0, 8'hD0, 8'hD5,
        8'h43, 8'h53, 8'h63,
        8'hE0, 8'hE2, 8'hE3, 8'hF0, 8'hF2, 8'hF3: len_m1 = 2'd1;
        default:                                  len_m1 = 2'd0;
      endcase
    end
    return len_m1;
  endfunction

  logic [2:0] phase_r,  phase_s;
  logic [1:0] cycles_r, cycles_s;
  fsm_t       fsm_r,    fsm_s;
  logic       first_r,  first_s;
  logic       reti_r,   reti_s;    // current instruction is RETI
  logic       int_take_s;
  logic       fetch_stb_s;
  logic       ack_stb_s;

`ifdef MC_SEQ_INT_EN
  // An interrupt may not follow RETI or another slot directly.
  assign int_take_s = int_req && (fsm_r != ISLOT) && !reti_r;
  assign int_ack    = ack_stb_s;
`else
  logic int_unused_s;
  assign int_take_s   = 1'b0;
  assign int_ack      = 1'b0;
  assign int_unused_s = int_req ^ reti_r ^ ack_stb_s;
`endif

  // Next-state logic: phase advance, length decode and cycle transitions.
  always_comb begin
    phase_s  = phase_r;
    cycles_s = cycles_r;
    fsm_s    = fsm_r;
    first_s  = first_r;
    reti_s   = reti_r;
    case (phase_r)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
        phase_s = phase_r + 3'd1;
        // The length is captured only here, so later IR changes are ignored.
        if ((fsm_r == FETCH) && (phase_r == 3'd2)) begin
          cycles_s = decode_len(IR);
          reti_s   = (IR == 8'h32);
        end else begin
          cycles_s = cycles_r;
        end
      end
      3'd6: begin
        phase_s = 3'd1;
        if (cycles_r != 2'd0) begin
          cycles_s = cycles_r - 2'd1;
          first_s  = 1'b0;
          if (fsm_r == ISLOT) begin
            fsm_s = ISLOT;
          end else begin
            fsm_s = EXEC;
          end
        end else if (int_take_s) begin
          fsm_s    = ISLOT;
          cycles_s = 2'd1;
          first_s  = 1'b1;
        end else begin
          fsm_s    = FETCH;
          cycles_s = 2'd0;
          first_s  = 1'b1;
        end
      end
      default: begin
        // An illegal phase encoding restarts cleanly at a fresh fetch.
        phase_s  = 3'd1;
        cycles_s = 2'd0;
        fsm_s    = FETCH;
        first_s  = 1'b1;
      end
    endcase
  end

  // Strobe decode: only on S1 of a first cycle, suppressed by stall and rst.
  always_comb begin
    fetch_stb_s = 1'b0;
    ack_stb_s   = 1'b0;
    if ((phase_r == 3'd1) && first_r && !stall && !rst) begin
      case (fsm_r)
        FETCH: begin
          fetch_stb_s = 1'b1;
          ack_stb_s   = 1'b0;
        end
        ISLOT: begin
          fetch_stb_s = 1'b0;
          ack_stb_s   = 1'b1;
        end
        default: begin
          fetch_stb_s = 1'b0;
          ack_stb_s   = 1'b0;
        end
      endcase
    end else begin
      fetch_stb_s = 1'b0;
      ack_stb_s   = 1'b0;
    end
  end

  // State register: reset wins over stall, stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r  <= 3'd1;
      cycles_r <= 2'd0;
      fsm_r    <= FETCH;
      first_r  <= 1'b1;
      reti_r   <= 1'b0;
    end else if (!stall) begin
      phase_r  <= phase_s;
      cycles_r <= cycles_s;
      fsm_r    <= fsm_s;
      first_r  <= first_s;
      reti_r   <= reti_s;
    end else begin
      phase_r  <= phase_r;
      cycles_r <= cycles_r;
      fsm_r    <= fsm_r;
      first_r  <= first_r;
      reti_r   <= reti_r;
    end
  end

  assign state  = phase_r;
  assign cycles = cycles_r;
  assign first  = first_r;
  assign IR_en  = fetch_stb_s;
  assign PC_inc = fetch_stb_s;

endmodule

// File: tb/tb_mc_seq.sv
// Directed bench for mc_seq. Every expected strobe (IR_en+PC_inc pair or
// int_ack) is queued with the clock index at which it must appear. Each
// clock pops and compares whatever the sequencer emits. Phase, cycles and
// first are checked against values computed from the instruction length.
module tb_mc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [7:0] IR;
  logic       int_req;
  logic [2:0] state;
  logic [1:0] cycles;
  logic       IR_en;
  logic       PC_inc;
  logic       int_ack;
  logic       first;

  always #5 clk = ~clk;

  mc_seq dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .IR      (IR),
    .int_req (int_req),
    .state   (state),
    .cycles  (cycles),
    .IR_en   (IR_en),
    .PC_inc  (PC_inc),
    .int_ack (int_ack),
    .first   (first)
  );

  typedef struct {
    logic [2:0] strb;   // {IR_en, PC_inc, int_ack}
    int         at;     // clock index at which it must appear
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   t           = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (clk %0d)", tag, obs, exp, t);
    end
  endtask

  // One clock: drive inputs just after the edge, sample strobes mid-cycle.
  task automatic step(input logic rst_v, input logic stall_v, input logic int_v);
    logic [2:0] obs;
    exp_t       e;
    @(posedge clk);
    #1;
    rst     = rst_v;
    stall   = stall_v;
    int_req = int_v;
    t++;
    @(negedge clk);
    obs = {IR_en, PC_inc, int_ack};
    if (obs !== 3'b000) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 32'(obs), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_kind", 32'(obs), 32'(e.strb));
        chk("strobe_time", 32'(t), 32'(e.at));
      end
    end else if ((sb_q.size() != 0) && (sb_q[0].at == t)) begin
      e = sb_q.pop_front();
      chk("missing_strobe", 32'(obs), 32'(e.strb));
    end
  endtask

  // One instruction of n machine cycles, optionally stalled at FETCH S1,
  // with int_req raised from step int_from (0 = never).
  task automatic run_instr(input logic [7:0] op, input int n, input int stall_n,
                           input int int_from);
    exp_t e;
    IR     = op;
    e.strb = 3'b110;
    e.at   = t + 1 + stall_n;
    sb_q.push_back(e);
    for (int s = 0; s < stall_n; s++) begin
      step(1'b0, 1'b1, int_from == 1);
      chk("stall_state", 32'(state), 32'd1);
      chk("stall_cycles", 32'(cycles), 32'd0);
    end
    for (int k = 1; k <= 6 * n; k++) begin
      int m;
      int p;
      int exp_cyc;
      m = (k - 1) / 6;
      p = (k - 1) % 6 + 1;
      step(1'b0, 1'b0, (int_from != 0) && (k >= int_from));
      exp_cyc = ((m == 0) && (p <= 2)) ? 0 : (n - 1 - m);
      chk("state", 32'(state), 32'(p));
      chk("cycles", 32'(cycles), 32'(exp_cyc));
      chk("first", 32'(first), 32'(m == 0));
      // Opcode changes after decode must not alter the instruction length.
      if (k == 3) IR = ~op;
    end
  endtask

  // Interrupt vector-call slot: two machine cycles, int_ack on its first S1.
  task automatic run_islot(input logic int_lvl);
    exp_t e;
    e.strb = 3'b001;
    e.at   = t + 1;
    sb_q.push_back(e);
    for (int k = 1; k <= 12; k++) begin
      int m;
      int p;
      m = (k - 1) / 6;
      p = (k - 1) % 6 + 1;
      step(1'b0, 1'b0, int_lvl);
      chk("islot_state", 32'(state), 32'(p));
      chk("islot_cycles", 32'(cycles), 32'((m == 0) ? 1 : 0));
      chk("islot_first", 32'(first), 32'(m == 0));
    end
  endtask

  logic [7:0] tbl_op [17] = '{8'h02, 8'h11, 8'hE1, 8'h91, 8'hBF, 8'hD8, 8'hD4, 8'h84,
                              8'hFF, 8'hB3, 8'h90, 8'hA5, 8'h73, 8'hF3, 8'h63, 8'h82,
                              8'h80};
  int         tbl_n  [17] = '{2, 2, 2, 2, 2, 2, 1, 4,
                              1, 1, 2, 1, 2, 2, 2, 1,
                              2};

  initial begin
    exp_t e;
    rst     = 1'b1;
    stall   = 1'b0;
    IR      = 8'h00;
    int_req = 1'b0;

    // Reset values, strobes quiet while rst is high.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_first", 32'(first), 32'd1);
    chk("rst_strobes", 32'({IR_en, PC_inc, int_ack}), 32'd0);

    // Single-cycle NOPs: fetch every 6 clocks from the first clock after reset.
    repeat (3) run_instr(8'h00, 1, 0, 0);

    // MUL: four machine cycles, cycles counts 3,2,1,0.
    run_instr(8'hA4, 4, 0, 0);

    // Length decode across the opcode map.
    for (int i = 0; i < 17; i++) run_instr(tbl_op[i], tbl_n[i], 0, 0);

    // Stall held at FETCH S1, then a stalled multi-cycle instruction.
    run_instr(8'h00, 1, 5, 0);
    run_instr(8'h02, 2, 2, 0);

    // Reset during EXEC S4 of DIV abandons it and refetches at once.
    IR     = 8'h84;
    e.strb = 3'b110;
    e.at   = t + 1;
    sb_q.push_back(e);
    for (int k = 1; k <= 9; k++) step(1'b0, 1'b0, 1'b0);
    chk("div_mid_state", 32'(state), 32'd3);
    chk("div_mid_cycles", 32'(cycles), 32'd2);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_clk_state", 32'(state), 32'd4);
    chk("rst_clk_first", 32'(first), 32'd0);
    run_instr(8'h00, 1, 0, 0);

`ifdef MC_SEQ_INT_EN
    // LJMP with int_req from S3: slot after the second cycle, refetch 12 clks on.
    run_instr(8'h02, 2, 0, 3);
    run_islot(1'b1);
    run_instr(8'h00, 1, 0, 0);
    // RETI: one more instruction runs before the slot.
    run_instr(8'h32, 2, 0, 1);
    run_instr(8'h00, 1, 0, 1);
    run_islot(1'b0);
    run_instr(8'h00, 1, 0, 0);
    // Reset inside a slot: no second int_ack, straight back to fetch.
    run_instr(8'h00, 1, 0, 6);
    e.strb = 3'b001;
    e.at   = t + 1;
    sb_q.push_back(e);
    for (int k = 1; k <= 3; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_instr(8'h00, 1, 0, 0);
`else
    // Without the interrupt option int_req never produces a slot.
    run_instr(8'h02, 2, 0, 3);
    run_instr(8'h00, 1, 0, 1);
    run_instr(8'h32, 2, 0, 1);
    run_instr(8'h00, 1, 0, 0);
`endif

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_seq.md
MC_SEQ -- requirements
Module: mc_seq

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 stall  input  1  hold request; when 1, every internal register keeps its value.
REQ-004 IR  input  8  current opcode held in the instruction register, valid from the phase after IR_en.
REQ-005 int_req  input  1  pending, already-prioritised interrupt request level.
REQ-006 state  output  3  current phase of the machine cycle, S1..S6 encoded 3'd1..3'd6.
REQ-007 cycles  output  2  machine cycles remaining in the current instruction after this one.
REQ-008 IR_en  output  1  IR load strobe, one clk wide.
REQ-009 PC_inc  output  1  program-counter increment strobe for the opcode fetch, one clk wide.
REQ-010 int_ack  output  1  interrupt vector-call slot start, one clk wide.
REQ-011 first  output  1  1 throughout the first machine cycle of an instruction or interrupt slot.

Function
REQ-012 Each machine cycle SHALL be exactly six non-stalled clks: phases S1..S6 in order, S6 wrapping to S1.
REQ-013 FSM states SHALL be FETCH (first machine cycle of an instruction), EXEC (remaining machine cycles) and ISLOT (interrupt vector-call slot).
REQ-014 In FETCH at S1 and with stall=0, the block SHALL assert IR_en and PC_inc together for that one clk.
REQ-015 At FETCH S2, the block SHALL decode IR and load cycles with N-1, where N is the instruction length in machine cycles.
REQ-016 N=4 SHALL apply to 0x84 (DIV) and 0xA4 (MUL).
REQ-017 N=2 SHALL apply to the following opcodes:
- AJMP/ACALL (IR[4:0]=5'b00001 or 5'b10001).
- 0x02, 0x12, 0x22, 0x32.
- 0x10, 0x20, 0x30, 0x40, 0x50, 0x60, 0x70, 0x80.
- 0x73, 0x83, 0x93, 0x90, 0xA3, 0xC0, 0xD0, 0xD5.
- 0x43, 0x53, 0x63.
- 0xE0, 0xE2, 0xE3, 0xF0, 0xF2, 0xF3.
- 0xB4-0xBF, 0xD8-0xDF.
REQ-018 N=1 SHALL apply to every opcode not listed in REQ-016 or REQ-017.
REQ-019 On each S6->S1 transition with cycles>0, the block SHALL decrement cycles, enter EXEC and clear first.
REQ-020 On an S6->S1 transition with cycles=0, the block SHALL start a new instruction (FETCH, first=1), unless REQ-021 applies.
REQ-021 int_req SHALL be sampled only at S6 of the final cycle (cycles=0) of FETCH/EXEC; if 1, the next cycle SHALL be ISLOT.
REQ-022 ISLOT SHALL behave as follows:
- Lasts 2 machine cycles, first=1 in its first cycle.
- cycles=1 from its S1.
- int_ack=1 at its first S1 only.
- IR_en=0 and PC_inc=0 throughout.
REQ-023 int_req SHALL be ignored when the final cycle belongs to opcode 0x32 (RETI) or to an ISLOT, so that at least one instruction executes between interrupt calls.
REQ-024 IR_en, PC_inc and int_ack SHALL be mutually exclusive.
REQ-025 While stall=1, all strobes SHALL be 0, and the pending strobe SHALL reappear on the first clk with stall=0.
REQ-026 The decoded N SHALL be captured once at S2; changes to IR later in the instruction SHALL be ignored.

Reset
REQ-027 With rst=1, the block SHALL load state=3'd1, cycles=0, FSM=FETCH, first=1, and clear IR_en, PC_inc and int_ack for that clk.
REQ-028 After rst falls, the first clk SHALL be FETCH S1 with IR_en=1 and PC_inc=1 (if stall=0).
REQ-029 rst SHALL have priority over stall, and rst during any phase or ISLOT SHALL abandon the instruction without an int_ack.

Configuration
REQ-030 Macro MC_SEQ_INT_EN defined: the block SHALL implement ISLOT and REQ-021..REQ-023.
REQ-031 Macro MC_SEQ_INT_EN undefined: the block SHALL ignore int_req, tie int_ack to 0 and never reach ISLOT.

Verification
REQ-032 Release rst with IR=0x00 and stall=0 -> IR_en at clks 1, 7 and 13; state sequence 1..6 repeating; cycles=0 throughout.
REQ-033 IR=0xA4 -> cycles reads 3,2,1,0 across four machine cycles; next IR_en 24 clks after the previous one.
REQ-034 IR=0x02 with int_req=1 from S3 -> int_ack at the S1 following the second cycle; next IR_en 12 clks later.
REQ-035 IR=0x32 with int_req=1 held -> one further 1-cycle instruction is fetched before int_ack.
REQ-036 stall=1 for 5 clks at FETCH S1 -> no strobes while stalled; IR_en fires on release; state stays at 1 during the stall.
REQ-037 rst pulsed at EXEC S4 of 0x84 -> next clk state=1, cycles=0, first=1, IR_en=1.
